// File: rtl/aes_word_loader_if.sv
// aes_word_loader_if: word stream in, AES_128 core link, and 128-bit result stream out
interface aes_word_loader_if;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic         in_is_key;
   logic [127:0] aes_key;
   logic [127:0] aes_state;
   logic [127:0] aes_out;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         key_loaded;
   logic         busy;
   modport slave (
      input  in_valid, in_data, in_is_key, aes_out, out_ready,
      output in_ready, aes_key, aes_state, out_valid, out_data, key_loaded, busy
   );
   modport master (
      output in_valid, in_data, in_is_key, aes_out, out_ready,
      input  in_ready, aes_key, aes_state, out_valid, out_data, key_loaded, busy
   );
endinterface

// File: rtl/aes_word_loader.sv
// aes_word_loader: assembles key/state words for AES_128, waits a settle time, captures the result
module aes_word_loader #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input logic clk,
   input logic rst_n,
   aes_word_loader_if.slave bus
);
   typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;
   state_t state, next_state;
   logic [127:0] key_reg, state_reg, out_reg;
   logic [1:0] key_cnt, data_cnt;
   logic key_loaded, pending;
   logic [CNT_W-1:0] settle;
   logic in_fire, key_fire, data_fire, key_wrap, data_wrap, launch;
   assign bus.in_ready   = rst_n && state == FILL;
   assign bus.aes_key    = key_reg;
   assign bus.aes_state  = state_reg;
   assign bus.out_data   = out_reg;
   assign bus.out_valid  = state == HOLD;
   assign bus.busy       = state != FILL;
   assign bus.key_loaded = key_loaded;
   assign in_fire   = bus.in_valid && bus.in_ready;
   assign key_fire  = in_fire && bus.in_is_key;
   assign data_fire = in_fire && !bus.in_is_key;
   assign key_wrap  = key_fire && key_cnt == 2'd3;
   assign data_wrap = data_fire && data_cnt == 2'd3;
   // a full block waits (pending) until the key is complete; completing it in the same cycle counts
   assign launch    = (data_wrap || pending) && (key_loaded || key_wrap);
   always_comb begin
      next_state = (state == FILL && launch)          ? RUN  :
                   (state == RUN  && settle == '0)    ? HOLD :
                   (state == HOLD && bus.out_ready)   ? FILL : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FILL;
         key_reg    <= '0;
         state_reg  <= '0;
         out_reg    <= '0;
         key_cnt    <= '0;
         data_cnt   <= '0;
         key_loaded <= 1'b0;
         pending    <= 1'b0;
         settle     <= '0;
      end else begin
         state <= next_state;
         if (key_fire) begin
            key_reg    <= {key_reg[95:0], bus.in_data};
            key_cnt    <= key_cnt + 2'd1;
            key_loaded <= key_cnt == 2'd3;
         end
         if (data_fire) begin
            state_reg <= {state_reg[95:0], bus.in_data};
            data_cnt  <= data_cnt + 2'd1;
         end
         pending <= launch ? 1'b0 : (data_wrap ? 1'b1 : pending);
         if (launch)
            settle <= CNT_W'(SETTLE_CYCLES - 1);
         else if (state == RUN)
            settle <= settle - 1'b1;
         if (state == RUN && settle == '0)
            out_reg <= bus.aes_out;
      end
   end
endmodule

// File: tb/tb_aes_word_loader.sv
// tb_aes_word_loader: directed vectors against a table-driven AES_128 stand-in
module tb_aes_word_loader;
   localparam int SETTLE = 2;
   localparam logic [127:0] K1 = 128'he4dc18adf3d05ec9e4dcc41acb990007;
   localparam logic [127:0] S1 = 128'h4072da1240f930f7d3c8cf8b9322042e;
   localparam logic [127:0] R1 = 128'hd225406f484809186cb5d86be4098445;
   localparam logic [127:0] K2 = 128'h1209239bbbe23cca9c3c8ccf138f54e0;
   localparam logic [127:0] S2 = 128'h110687e2636afdb84c12653d55f3bae1;
   localparam logic [127:0] R2 = 128'h5867142e883b431b428fc33306a272de;
   logic clk = 1'b0;
   logic rst_n;
   int n_chk = 0, n_pass = 0;
   aes_word_loader_if bus ();
   aes_word_loader #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // known AES_128 vectors; any other pairing yields key^state so mis-pairings are visible
   assign bus.aes_out = (bus.aes_key == K1 && bus.aes_state == S1) ? R1 :
                        (bus.aes_key == K2 && bus.aes_state == S2) ? R2 : bus.aes_key ^ bus.aes_state;
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic send(input logic k, input logic [31:0] d);
      bus.in_valid = 1'b1; bus.in_is_key = k; bus.in_data = d;
      for (int i = 0; i < 50 && !bus.in_ready; i++) @(negedge clk);
      if (!bus.in_ready) check("send_timeout", 0, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask
   task automatic send_part(input logic k, input logic [127:0] v, input int first, input int last);
      for (int i = first; i <= last; i++) send(k, v[127-32*i -: 32]);
   endtask
   task automatic wait_valid(input string tag);
      int cyc = 1;
      @(negedge clk);
      while (!bus.out_valid && cyc < 50) begin cyc++; @(negedge clk); end
      check(tag, 128'(cyc), 128'(SETTLE + 1));
   endtask
   task automatic handshake();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("hs_out_valid", bus.out_valid, 0);
      check("hs_in_ready", bus.in_ready, 1);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_is_key = 1'b0; bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_key_loaded", bus.key_loaded, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready", bus.in_ready, 1);
      // state block first, key completes last
      send_part(0, S2, 0, 3);
      repeat (3) @(negedge clk);
      check("il_no_launch", bus.busy, 0);
      check("il_key_loaded", bus.key_loaded, 0);
      send_part(1, K2, 0, 3);
      wait_valid("il_latency");
      check("il_out_data", bus.out_data, R2);
      handshake();
      // key then block
      send_part(1, K1, 0, 3);
      check("kb_key_loaded", bus.key_loaded, 1);
      check("kb_aes_key", bus.aes_key, K1);
      send_part(0, S1, 0, 3);
      check("kb_aes_state", bus.aes_state, S1);
      wait_valid("kb_latency");
      check("kb_out_data", bus.out_data, R1);
      check("kb_in_ready", bus.in_ready, 0);
      check("kb_busy", bus.busy, 1);
      handshake();
      // key reuse, out_ready already high on entry to HOLD
      bus.out_ready = 1'b1;
      send_part(0, S1, 0, 3);
      wait_valid("ru_latency");
      check("ru_out_data", bus.out_data, R1);
      check("ru_key_loaded", bus.key_loaded, 1);
      @(negedge clk);
      check("ru_one_cycle", bus.out_valid, 0);
      check("ru_in_ready", bus.in_ready, 1);
      bus.out_ready = 1'b0;
      // backpressure with K1 and S2
      send_part(0, S2, 0, 3);
      wait_valid("bp_latency");
      for (int i = 0; i < 20; i++) begin
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_out_data", bus.out_data, K1 ^ S2);
         check("bp_in_ready", bus.in_ready, 0);
         @(negedge clk);
      end
      handshake();
      // partial key blocks launch
      send_part(1, K2, 0, 1);
      check("pk_key_loaded", bus.key_loaded, 0);
      send_part(0, S2, 0, 3);
      repeat (4) @(negedge clk);
      check("pk_no_launch", bus.busy, 0);
      send_part(1, K2, 2, 3);
      wait_valid("pk_latency");
      check("pk_out_data", bus.out_data, R2);
      handshake();
      // reset during RUN
      send_part(0, S2, 0, 3);
      check("mr_busy", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      check("mr_busy0", bus.busy, 0);
      check("mr_in_ready", bus.in_ready, 0);
      check("mr_aes_key", bus.aes_key, 0);
      check("mr_aes_state", bus.aes_state, 0);
      check("mr_key_loaded", bus.key_loaded, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mr_rel_in_ready", bus.in_ready, 1);
      check("mr_rel_key_loaded", bus.key_loaded, 0);
      check("mr_rel_out_valid", bus.out_valid, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/aes_word_loader.md
Name: aes_word_loader

Overview:
- Upstream feeder and result-capture stage for the combinational AES_128 core.
- Accepts 32-bit words over a valid/ready stream and assembles a 128-bit key and a 128-bit state block.
- Drives the assembled key and state to AES_128 and holds them stable for a programmable settle time.
- Captures the AES_128 output into a register and presents it on a 128-bit valid/ready result port. Key is retained across blocks until reloaded.

Parameters:
- SETTLE_CYCLES, 2, cycles the key/state are held stable at AES_128 before the output is sampled (1..15).
- CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  loader accepts a word this cycle
- in_data  input  32  input word, most-significant word first
- in_is_key  input  1  1 = word belongs to key, 0 = word belongs to state
- aes_key  output  128  key to AES_128 .key
- aes_state  output  128  block to AES_128 .state
- aes_out  input  128  result from AES_128 .out
- out_valid  output  1  captured result valid
- out_ready  input  1  downstream accepts result
- out_data  output  128  captured AES result
- key_loaded  output  1  a complete 128-bit key is held
- busy  output  1  high in RUN or HOLD

Behaviour:
- Reset (async, rst_n=0):
  - State goes to FILL. key_reg, state_reg and out_data clear to 0.
  - key_cnt and data_cnt clear to 0. key_loaded=0, out_valid=0, busy=0.
  - in_ready is 0 during reset.
  - Reset mid-operation discards any partial words and any pending result.
- Word transfer: occurs when in_valid && in_ready. in_ready=1 only in FILL.
- Key word accepted:
  - key_reg <= {key_reg[95:0], in_data}; key_cnt increments.
  - When key_cnt wraps 3->0, key_loaded <= 1.
  - When the first word of a new key is accepted (key_cnt==0), key_loaded <= 0 until 4 words are accepted.
- State word accepted: state_reg shifts in the same way; data_cnt increments.
- Launch condition: data_cnt wraps 3->0. On that cycle:
  - If key_loaded=1, or the same-cycle word completes the key, go to RUN.
  - Otherwise the block is held and the FSM stays in FILL with a pending-launch flag. It moves to RUN the cycle after the 4th key word is accepted.
- Interleaving: key and state words may interleave freely; each stream keeps its own counter.
- Output wiring: aes_key = key_reg and aes_state = state_reg, continuously.
- FSM:
  - FILL: transitions as above.
  - RUN: settle counter loads SETTLE_CYCLES-1 on entry and decrements each cycle. At 0, out_data <= aes_out, out_valid <= 1, go to HOLD.
  - HOLD: out_valid=1. When out_ready=1, out_valid <= 0 and go to FILL.
- Latency: the 4th state word is accepted in cycle N. out_valid rises in cycle N+SETTLE_CYCLES+1 (registered).
- Stability: key_reg and state_reg do not change in RUN or HOLD (in_ready=0). out_data does not change while out_valid=1.
- Back-to-back: in_ready rises the cycle after the out handshake. There is no overlap of fill and output.
- Simultaneous events: out_valid and out_ready both high on entry to HOLD completes the handshake in that same cycle.
- Key reuse: the key persists across blocks. A block sent with no new key words uses the last complete key.

Test Plan:
- Reset: assert rst_n=0 mid-RUN -> all outputs 0 immediately, in_ready=0. After release: in_ready=1, key_loaded=0.
- Key then block:
  - Stimulus: key words e4dc18ad,f3d05ec9,e4dcc41a,cb990007, then state words 4072da12,40f930f7,d3c8cf8b,9322042e, with real AES_128 attached.
  - Required: out_data=d225406f484809186cb5d86be4098445 and out_valid exactly SETTLE_CYCLES+1 cycles after the last word.
- Interleaved, key completes last:
  - Stimulus: state words 110687e2,636afdb8,4c12653d,55f3bae1 first, then key 1209239b,bbe23cca,9c3c8ccf,138f54e0.
  - Required: launch waits for key_loaded; out_data=5867142e883b431b428fc33306a272de.
- Key reuse: after test 2, send a state-only block 4072da12..9322042e -> out_data=d225406f484809186cb5d86be4098445, key_loaded stays 1.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and out_data stable, in_ready=0. Raise out_ready -> out_valid drops next cycle, in_ready=1.
- Partial key: send 2 key words after a loaded key -> key_loaded=0. A completed state block does not launch until 2 more key words arrive.
